alarm_scheduler: RTL and testbench
==================================

Name: alarm_scheduler

Overview:
- Multi-slot alarm controller that sits beside the time-of-day counter (clk/clr domain, 8-bit binary hr/min/sec outputs).
- Holds NUM_ALM programmable alarm times and compares them against the running time on each second tick.
- Sequences the ring / snooze / stop behaviour and drives the single alarm output.
- Replaces direct poking of alarm registers with a proper configuration write port.

Parameters:
- NUM_ALM, 4, number of alarm slots (index width IW = clog2(NUM_ALM), minimum 1).
- RING_SECS, 30, ticks the alarm rings before auto-timeout.
- SNOOZE_SECS, 300, ticks spent in snooze before re-ringing (counter width 16).
- MAX_SNOOZE, 3, snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- tick  in  1  1-cycle pulse; hr/min/sec hold the new second value on this cycle.
- hr  in  8  current hour, 0-23.
- min  in  8  current minute, 0-59.
- sec  in  8  current second, 0-59.
- cfg_we  in  1  slot write strobe.
- cfg_idx  in  IW  slot index.
- cfg_en  in  1  slot enable written with the time.
- cfg_hr / cfg_min / cfg_sec  in  8 each  alarm time.
- snooze_btn  in  1  debounced 1-cycle pulse.
- stop_btn  in  1  debounced 1-cycle pulse.
- alarm  out  1  ring output.
- ring_idx  out  IW  slot that triggered the current event.
- snooze_cnt  out  2  snoozes used in the current event.
- state  out  2  00 IDLE, 01 RINGING, 10 SNOOZE.
- cfg_err  out  1  1-cycle pulse: write rejected.
- missed  out  1  1-cycle pulse: a match was dropped.

Behaviour:
- Reset (clr=1 at posedge):
  - All slots disabled, slot times 0.
  - state=IDLE; alarm, ring_idx, snooze_cnt, cfg_err and missed all 0.
  - Ring and snooze counters 0.
  - clr overrides every other input, including mid-ring; alarm drops the cycle after.
- Config write:
  - Accepted when cfg_we=1, cfg_hr<=23, cfg_min<=59, cfg_sec<=59 and cfg_idx<NUM_ALM.
  - Otherwise the slot is unchanged and cfg_err pulses on the next cycle.
  - A write in the same cycle as tick: the match uses the old slot contents; the new value takes effect next cycle.
  - A write to the ringing slot does not abort the event.
- Match: on tick, a slot matches when enabled and hr/min/sec are all equal. If several match, the lowest index wins.
- IDLE:
  - A match moves to RINGING; alarm=1 and ring_idx=winner from the next cycle (1-cycle latency from tick).
  - Ring counter and snooze_cnt are cleared.
- RINGING:
  - Each tick increments the ring counter.
  - When the counter reaches RING_SECS, go to IDLE and set alarm=0 (timeout).
  - stop_btn -> IDLE.
  - snooze_btn with snooze_cnt<MAX_SNOOZE -> SNOOZE: alarm=0, snooze_cnt+1, snooze counter cleared.
  - snooze_btn with snooze_cnt==MAX_SNOOZE is ignored; ringing continues.
- SNOOZE:
  - alarm=0. Each tick increments the snooze counter.
  - When the counter reaches SNOOZE_SECS, go to RINGING with the ring counter cleared and the same ring_idx.
  - stop_btn -> IDLE.
- Simultaneous events:
  - stop_btn and snooze_btn together: stop wins.
  - A button and a timeout tick in the same cycle: the button wins.
  - A new match while RINGING/SNOOZE is not queued: missed pulses, and ring_idx is unchanged.
- Leaving to IDLE clears snooze_cnt on the following cycle. ring_idx holds its last value.
- Buttons in IDLE are ignored.

Decomposition:
- Shared package (alarm_pkg):
  - state encoding constants ST_IDLE, ST_RING, ST_SNOOZE.
  - Time limit constants HR_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - Slot record typedef {en, hr, min, sec}.
- Sub-module alarm_slot_match:
  - Slot register array, the write-validity check, and the per-slot equality.
  - Lowest-index priority encoder producing match_any and match_idx.
- Top level: FSM, counters and output registers.

Test Plan:
- Reset, then write slot0=00:00:07 en=1; drive ticks from 00:00:00 -> alarm rises the cycle after the tick showing 00:00:07; ring_idx=0; state=01.
- Ring with no buttons, RING_SECS=4 -> alarm falls after the 4th tick; state=00; missed=0.
- Ringing, then snooze_btn -> alarm=0, snooze_cnt=1, state=10. After SNOOZE_SECS ticks (set to 5) -> alarm=1 again. Snooze 3 times; the 4th snooze_btn is ignored and alarm stays 1; stop_btn -> state=00, snooze_cnt=0.
- Slots 1 and 2 both at 00:00:03 -> ring_idx=1. Slot3=00:00:05 matches while ringing -> missed pulses once; ring_idx stays 1.
- Write cfg_hr=24 to slot0 -> cfg_err=1 for one cycle; slot0 unchanged (still fires at 00:00:07). Write slot0 on the same cycle as its matching tick -> old value fires.
- Assert clr while RINGING, and snooze_btn+stop_btn together while RINGING -> all outputs 0 the cycle after clr; stop wins (state=00, snooze_cnt 0).

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm scheduler: FSM encoding, time limits,
// the alarm slot record and the time-validity helper.
package alarm_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RING   = 2'b01;
    localparam logic [1:0] ST_SNOOZE = 2'b10;

    localparam logic [7:0] HR_MAX  = 8'd23;
    localparam logic [7:0] MIN_MAX = 8'd59;
    localparam logic [7:0] SEC_MAX = 8'd59;

    typedef struct packed {
        logic       en;
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
    } slot_t;

    function automatic logic time_valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return (h <= HR_MAX) && (m <= MIN_MAX) && (s <= SEC_MAX);
    endfunction

endpackage

// File: rtl/alarm_slot_match.sv
// Alarm slot storage with validated configuration writes and a
// lowest-index-wins match encoder evaluated on each second tick.
module alarm_slot_match import alarm_pkg::*; #(
    parameter int NUM_ALM = 4,
    parameter int IW      = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          tick,
    input  logic [7:0]    hr,
    input  logic [7:0]    min,
    input  logic [7:0]    sec,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic          cfg_en,
    input  logic [7:0]    cfg_hr,
    input  logic [7:0]    cfg_min,
    input  logic [7:0]    cfg_sec,
    output logic          match_any,
    output logic [IW-1:0] match_idx,
    output logic          cfg_err
);

    slot_t slot_q [NUM_ALM];
    slot_t slot_d [NUM_ALM];
    logic  cfg_err_q;
    logic  cfg_err_d;
    logic  cfg_ok;

    // Next-state of the slot array; matching below reads slot_q, so a write
    // on a tick cycle only affects matches from the following cycle.
    always_comb begin
        slot_d    = slot_q;
        cfg_ok    = cfg_we && time_valid(cfg_hr, cfg_min, cfg_sec) && (int'(cfg_idx) < NUM_ALM);
        cfg_err_d = cfg_we && !cfg_ok;
        if (cfg_ok) begin
            slot_d[cfg_idx] = '{en: cfg_en, hr: cfg_hr, min: cfg_min, sec: cfg_sec};
        end else begin
            slot_d[0] = slot_q[0];
        end
    end

    // Priority encoder: scanning downwards leaves the lowest matching index.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALM - 1; i >= 0; i--) begin
            if (tick && slot_q[i].en && (slot_q[i].hr == hr) &&
                (slot_q[i].min == min) && (slot_q[i].sec == sec)) begin
                match_any = 1'b1;
                match_idx = IW'(i);
            end else begin
                match_any = match_any;
            end
        end
    end

    // Slot and error-pulse registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            slot_q    <= '{default: '0};
            cfg_err_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: ring / snooze / stop sequencing driven by the
// per-second tick, with all outputs registered.
module alarm_scheduler import alarm_pkg::*; #(
    parameter int NUM_ALM     = 4,
    parameter int RING_SECS   = 30,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int IW          = (NUM_ALM > 1) ? $clog2(NUM_ALM) : 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          tick,
    input  logic [7:0]    hr,
    input  logic [7:0]    min,
    input  logic [7:0]    sec,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic          cfg_en,
    input  logic [7:0]    cfg_hr,
    input  logic [7:0]    cfg_min,
    input  logic [7:0]    cfg_sec,
    input  logic          snooze_btn,
    input  logic          stop_btn,
    output logic          alarm,
    output logic [IW-1:0] ring_idx,
    output logic [1:0]    snooze_cnt,
    output logic [1:0]    state,
    output logic          cfg_err,
    output logic          missed
);

    localparam logic [15:0] RING_LIM = 16'(RING_SECS);
    localparam logic [15:0] SNZ_LIM  = 16'(SNOOZE_SECS);
    localparam logic [1:0]  SNZ_MAX  = 2'(MAX_SNOOZE);

    logic          match_any;
    logic [IW-1:0] match_idx;

    logic [1:0]    state_q, state_d;
    logic          alarm_q, alarm_d;
    logic [IW-1:0] ring_idx_q, ring_idx_d;
    logic [1:0]    snooze_cnt_q, snooze_cnt_d;
    logic [15:0]   ring_cnt_q, ring_cnt_d;
    logic [15:0]   snz_cnt_q, snz_cnt_d;
    logic          missed_q, missed_d;

    alarm_slot_match #(.NUM_ALM(NUM_ALM), .IW(IW)) u_match (
        .clk       (clk),
        .clr       (clr),
        .tick      (tick),
        .hr        (hr),
        .min       (min),
        .sec       (sec),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_en    (cfg_en),
        .cfg_hr    (cfg_hr),
        .cfg_min   (cfg_min),
        .cfg_sec   (cfg_sec),
        .match_any (match_any),
        .match_idx (match_idx),
        .cfg_err   (cfg_err)
    );

    // Event sequencer; priority inside an event is stop > snooze > tick.
    always_comb begin
        state_d      = state_q;
        alarm_d      = alarm_q;
        ring_idx_d   = ring_idx_q;
        snooze_cnt_d = snooze_cnt_q;
        ring_cnt_d   = ring_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        missed_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (match_any) begin
                    state_d      = ST_RING;
                    alarm_d      = 1'b1;
                    ring_idx_d   = match_idx;
                    ring_cnt_d   = 16'd0;
                    snooze_cnt_d = 2'd0;
                end else begin
                    alarm_d      = 1'b0;
                    snooze_cnt_d = 2'd0;
                end
            end
            ST_RING: begin
                missed_d = match_any;
                if (stop_btn) begin
                    state_d      = ST_IDLE;
                    alarm_d      = 1'b0;
                    snooze_cnt_d = 2'd0;
                end else if (snooze_btn && (snooze_cnt_q < SNZ_MAX)) begin
                    state_d      = ST_SNOOZE;
                    alarm_d      = 1'b0;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                    snz_cnt_d    = 16'd0;
                end else if (tick) begin
                    if ((ring_cnt_q + 16'd1) >= RING_LIM) begin
                        state_d      = ST_IDLE;
                        alarm_d      = 1'b0;
                        snooze_cnt_d = 2'd0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + 16'd1;
                    end
                end else begin
                    ring_cnt_d = ring_cnt_q;
                end
            end
            ST_SNOOZE: begin
                missed_d = match_any;
                if (stop_btn) begin
                    state_d      = ST_IDLE;
                    alarm_d      = 1'b0;
                    snooze_cnt_d = 2'd0;
                end else if (tick) begin
                    if ((snz_cnt_q + 16'd1) >= SNZ_LIM) begin
                        state_d    = ST_RING;
                        alarm_d    = 1'b1;
                        ring_cnt_d = 16'd0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 16'd1;
                    end
                end else begin
                    snz_cnt_d = snz_cnt_q;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                alarm_d      = 1'b0;
                snooze_cnt_d = 2'd0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            alarm_q      <= 1'b0;
            ring_idx_q   <= '0;
            snooze_cnt_q <= 2'd0;
            ring_cnt_q   <= 16'd0;
            snz_cnt_q    <= 16'd0;
            missed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_q      <= alarm_d;
            ring_idx_q   <= ring_idx_d;
            snooze_cnt_q <= snooze_cnt_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            missed_q     <= missed_d;
        end
    end

    assign alarm      = alarm_q;
    assign ring_idx   = ring_idx_q;
    assign snooze_cnt = snooze_cnt_q;
    assign state      = state_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: directed vector table followed by randomized
// traffic checked against an event-level reference model.
module tb_alarm_scheduler;

    localparam int RING   = 4;
    localparam int SNOOZE = 5;
    localparam int MAXS   = 3;

    logic       clk = 1'b0;
    logic       clr, tick, cfg_we, cfg_en, snooze_btn, stop_btn;
    logic [7:0] hr, mn, sec, cfg_hr, cfg_min, cfg_sec;
    logic [1:0] cfg_idx;
    logic       alarm, cfg_err, missed;
    logic [1:0] ring_idx, snooze_cnt, state;

    int n_cmp = 0;
    int n_bad = 0;

    alarm_scheduler #(.NUM_ALM(4), .RING_SECS(RING), .SNOOZE_SECS(SNOOZE), .MAX_SNOOZE(MAXS)) dut (
        .clk(clk), .clr(clr), .tick(tick), .hr(hr), .min(mn), .sec(sec),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_hr(cfg_hr), .cfg_min(cfg_min), .cfg_sec(cfg_sec),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .alarm(alarm), .ring_idx(ring_idx), .snooze_cnt(snooze_cnt),
        .state(state), .cfg_err(cfg_err), .missed(missed)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       c, t, sz, sp, we, en;
        logic [1:0] ix;
        logic [7:0] s, ch, cs;
        logic [8:0] exp;   // {alarm, ring_idx, snooze_cnt, state, cfg_err, missed}
    } vec_t;

    vec_t vq[$];

    function automatic void add(string nm, logic c, logic t, logic [7:0] s, logic sz, logic sp,
                                logic we, logic [1:0] ix, logic en, logic [7:0] ch, logic [7:0] cs,
                                logic a, logic [1:0] ri, logic [1:0] sc, logic [1:0] st, logic er, logic ms);
        vec_t v;
        v.nm = nm; v.c = c; v.t = t; v.s = s; v.sz = sz; v.sp = sp;
        v.we = we; v.ix = ix; v.en = en; v.ch = ch; v.cs = cs;
        v.exp = {a, ri, sc, st, er, ms};
        vq.push_back(v);
    endfunction

    function automatic void tk(string nm, logic [7:0] s, logic a, logic [1:0] ri, logic [1:0] sc, logic [1:0] st, logic ms);
        add(nm, 1'b0, 1'b1, s, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0, a, ri, sc, st, 1'b0, ms);
    endfunction

    function automatic void bt(string nm, logic sz, logic sp, logic a, logic [1:0] ri, logic [1:0] sc, logic [1:0] st);
        add(nm, 1'b0, 1'b0, 8'd50, sz, sp, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0, a, ri, sc, st, 1'b0, 1'b0);
    endfunction

    function automatic void wr(string nm, logic [1:0] ix, logic en, logic [7:0] ch, logic [7:0] cs, logic er,
                               logic a, logic [1:0] ri, logic [1:0] sc, logic [1:0] st);
        add(nm, 1'b0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b1, ix, en, ch, cs, a, ri, sc, st, er, 1'b0);
    endfunction

    task automatic drive(logic c, logic t, logic [7:0] h, logic [7:0] m, logic [7:0] s, logic sz, logic sp,
                         logic we, logic [1:0] ix, logic en, logic [7:0] ch, logic [7:0] cm, logic [7:0] cs);
        clr = c; tick = t; hr = h; mn = m; sec = s; snooze_btn = sz; stop_btn = sp;
        cfg_we = we; cfg_idx = ix; cfg_en = en; cfg_hr = ch; cfg_min = cm; cfg_sec = cs;
    endtask

    task automatic check(string nm, logic [8:0] exp);
        logic [8:0] got;
        got = {alarm, ring_idx, snooze_cnt, state, cfg_err, missed};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got {alm,idx,scnt,st,err,miss}=%b required %b", nm, $time, got, exp);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    bit m_en[4];
    int m_h[4], m_m[4], m_s[4];
    bit m_active, m_ringing, m_err, m_miss;
    int m_ring_left, m_snz_left, m_snoozes, m_idx;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 1'b0; m_h[i] = 0; m_m[i] = 0; m_s[i] = 0;
        end
        m_active = 1'b0; m_ringing = 1'b0; m_err = 1'b0; m_miss = 1'b0;
        m_ring_left = 0; m_snz_left = 0; m_snoozes = 0; m_idx = 0;
    endtask

    task automatic model_step(bit c, bit t, int h, int m, int s, bit sz, bit sp,
                              bit we, int ix, bit en, int ch, int cm, int cs);
        int  win;
        bit  ok;
        if (c) begin
            model_reset();
            return;
        end
        ok    = (ch <= 23) && (cm <= 59) && (cs <= 59);
        m_err = we && !ok;
        m_miss = 1'b0;
        win = -1;
        if (t) begin
            for (int i = 3; i >= 0; i--)
                if (m_en[i] && m_h[i] == h && m_m[i] == m && m_s[i] == s) win = i;
        end
        if (!m_active) begin
            if (win >= 0) begin
                m_active = 1'b1; m_ringing = 1'b1; m_ring_left = RING;
                m_snoozes = 0; m_idx = win;
            end
        end else begin
            if (win >= 0) m_miss = 1'b1;
            if (sp) begin
                m_active = 1'b0; m_snoozes = 0;
            end else if (m_ringing && sz && m_snoozes < MAXS) begin
                m_ringing = 1'b0; m_snoozes++; m_snz_left = SNOOZE;
            end else if (t) begin
                if (m_ringing) begin
                    m_ring_left--;
                    if (m_ring_left == 0) begin
                        m_active = 1'b0; m_snoozes = 0;
                    end
                end else begin
                    m_snz_left--;
                    if (m_snz_left == 0) begin
                        m_ringing = 1'b1; m_ring_left = RING;
                    end
                end
            end
        end
        if (we && ok) begin
            m_en[ix] = en; m_h[ix] = ch; m_m[ix] = cm; m_s[ix] = cs;
        end
    endtask

    function automatic logic [8:0] model_out();
        logic [1:0] st;
        logic [1:0] ri;
        logic [1:0] sc;
        st = !m_active ? 2'b00 : (m_ringing ? 2'b01 : 2'b10);
        ri = m_idx[1:0];
        sc = m_snoozes[1:0];
        return {m_active && m_ringing, ri, sc, st, m_err, m_miss};
    endfunction

    initial begin
        // ---------------- directed table ----------------
        add("reset", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        wr("wr_slot0", 2'd0, 1'b1, 8'd0, 8'd7, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        tk("pre_tick", 8'd6, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        tk("fire_07", 8'd7, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0);
        for (int i = 0; i < RING - 1; i++) tk("ring_tick", 8'd40, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0);
        tk("timeout", 8'd40, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        tk("refire", 8'd7, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0);
        for (int k = 1; k <= MAXS; k++) begin
            bt("snooze", 1'b1, 1'b0, 1'b0, 2'd0, 2'(k), 2'd2);
            for (int j = 0; j < SNOOZE - 1; j++) tk("snooze_tick", 8'd40, 1'b0, 2'd0, 2'(k), 2'd2, 1'b0);
            tk("resume", 8'd40, 1'b1, 2'd0, 2'(k), 2'd1, 1'b0);
        end
        bt("snooze_max", 1'b1, 1'b0, 1'b1, 2'd0, 2'd3, 2'd1);
        bt("stop", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        wr("wr_slot1", 2'd1, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        wr("wr_slot2", 2'd2, 1'b1, 8'd0, 8'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        wr("wr_slot3", 2'd3, 1'b1, 8'd0, 8'd5, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        tk("priority", 8'd3, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0);
        tk("ring1", 8'd4, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0);
        tk("missed", 8'd5, 1'b1, 2'd1, 2'd0, 2'd1, 1'b1);
        tk("missed_once", 8'd6, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0);
        bt("both_btns", 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0);
        tk("fire_again", 8'd3, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0);
        for (int i = 0; i < RING - 1; i++) tk("ring_tick2", 8'd40, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0);
        add("snz_vs_timeout", 1'b0, 1'b1, 8'd40, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0);
        bt("stop_snooze", 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0);
        wr("bad_hr", 2'd0, 1'b1, 8'd24, 8'd9, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0);
        bt("err_pulse_end", 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0);
        tk("slot0_kept", 8'd7, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0);
        bt("stop3", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        add("wr_on_tick", 1'b0, 1'b1, 8'd7, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'd0, 8'd8, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0);
        bt("stop4", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        tk("new_slot0", 8'd8, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0);
        wr("wr_ringing", 2'd0, 1'b0, 8'd0, 8'd8, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1);
        tk("still_ring", 8'd40, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0);
        bt("stop5", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        tk("disabled", 8'd8, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        tk("fire_s1", 8'd3, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0);
        add("clr_ring", 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        tk("after_clr", 8'd3, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);

        foreach (vq[i]) begin
            drive(vq[i].c, vq[i].t, 8'd0, 8'd0, vq[i].s, vq[i].sz, vq[i].sp,
                  vq[i].we, vq[i].ix, vq[i].en, vq[i].ch, 8'd0, vq[i].cs);
            @(posedge clk);
            #1;
            check(vq[i].nm, vq[i].exp);
        end

        // ---------------- randomized traffic vs model ----------------
        model_reset();
        for (int n = 0; n < 6000; n++) begin
            bit         c, t, sz, sp, we, en;
            int         bad;
            logic [1:0] ix;
            logic [7:0] h, m, s, ch, cm, cs;
            c   = (n == 0) || ($urandom_range(0, 399) == 0);
            t   = $urandom_range(0, 1) == 1;
            sz  = $urandom_range(0, 5) == 0;
            sp  = $urandom_range(0, 11) == 0;
            we  = $urandom_range(0, 9) == 0;
            en  = $urandom_range(0, 3) != 0;
            ix  = 2'($urandom_range(0, 3));
            h   = 8'($urandom_range(0, 1));
            m   = 8'($urandom_range(0, 1));
            s   = 8'($urandom_range(0, 2));
            bad = $urandom_range(0, 7);
            ch  = (bad == 0) ? 8'($urandom_range(24, 255)) : 8'($urandom_range(0, 1));
            cm  = (bad == 1) ? 8'($urandom_range(60, 255)) : 8'($urandom_range(0, 1));
            cs  = (bad == 2) ? 8'($urandom_range(60, 255)) : 8'($urandom_range(0, 2));
            drive(c, t, h, m, s, sz, sp, we, ix, en, ch, cm, cs);
            model_step(c, t, int'(h), int'(m), int'(s), sz, sp, we, int'(ix), en, int'(ch), int'(cm), int'(cs));
            @(posedge clk);
            #1;
            check("random", model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
